// File: rtl/scsp_timer_irq.sv
// scsp_timer_irq
// Timer and interrupt controller for the SCSP common-control register block
// (offsets 0x18-0x2E). It holds the three sample-rate timers A/B/C, the
// sound-CPU (68K) pending/enable/level registers and the main-CPU pending/
// enable registers.
//
// Ports:
//   CLK        system clock
//   RST        asynchronous active-high reset
//   CE         clock enable; nothing advances while CE=0
//   SAMPLE_CE  one-CE-cycle pulse per output sample
//   REG_A      word address within the block (0-11)
//   REG_DI     write data
//   REG_WE     write strobe
//   REG_DO     combinational read data for REG_A
//   IRQ_SRC    external event pulses (bits 0-4 and 9 used)
//   SCU_IPL    registered 68K interrupt priority level
//   MAIN_INT   registered main-CPU interrupt request
module scsp_timer_irq (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE,
    input  logic        SAMPLE_CE,
    input  logic [4:0]  REG_A,
    input  logic [15:0] REG_DI,
    input  logic        REG_WE,
    output logic [15:0] REG_DO,
    input  logic [10:0] IRQ_SRC,
    output logic [2:0]  SCU_IPL,
    output logic        MAIN_INT
);

    logic [2:0]  tctl [3];
    logic [7:0]  tcnt [3];
    logic [6:0]  tps  [3];
    logic [2:0]  tim_wr;
    logic [2:0]  tim_hit;
    logic [2:0]  tim_ev;

    logic [10:0] scieb;
    logic [10:0] scipd;
    logic [7:0]  scilv0;
    logic [7:0]  scilv1;
    logic [7:0]  scilv2;
    logic [10:0] mcieb;
    logic [10:0] mcipd;

    logic [10:0] ev;
    logic [10:0] sc_clr;
    logic [10:0] mc_clr;
    logic [10:0] sc_sw;
    logic [10:0] mc_sw;
    logic [10:0] sc_active;
    logic [2:0]  ipl_next;
    logic [2:0]  lvl;
    logic [2:0]  k;

    // Timer step decode. The prescaler terminal value is 2^CTL-1; with
    // CTL=7 the 7-bit shift wraps to 0 and the subtraction yields 127, which
    // is exactly the required terminal count. A register write to a timer in
    // the same cycle as SAMPLE_CE suppresses both the step and its event.
    always_comb begin
        tim_wr  = '0;
        tim_hit = '0;
        tim_ev  = '0;
        for (int i = 0; i < 3; i++) begin
            tim_wr[i]  = REG_WE && (REG_A == 5'(i));
            tim_hit[i] = (tps[i] == ((7'd1 << tctl[i]) - 7'd1));
            tim_ev[i]  = SAMPLE_CE && !tim_wr[i] && tim_hit[i] && (tcnt[i] == 8'hFF);
        end
    end

    // Event vector and the write-side set/clear masks for both pending
    // registers. Bit 5 has no hardware source; it is set only by software.
    always_comb begin
        ev     = {SAMPLE_CE, IRQ_SRC[9], tim_ev, 1'b0, IRQ_SRC[4:0]};
        sc_clr = (REG_WE && REG_A == 5'd5)  ? REG_DI[10:0] : 11'd0;
        mc_clr = (REG_WE && REG_A == 5'd11) ? REG_DI[10:0] : 11'd0;
        sc_sw  = (REG_WE && REG_A == 5'd4  && REG_DI[5]) ? 11'h020 : 11'd0;
        mc_sw  = (REG_WE && REG_A == 5'd10 && REG_DI[5]) ? 11'h020 : 11'd0;
    end

    // 68K level: each active bit n looks up a 3-bit level from column
    // min(n,7) of the three SCILV registers; the highest level wins.
    always_comb begin
        ipl_next  = 3'd0;
        lvl       = 3'd0;
        k         = 3'd0;
        sc_active = scipd & scieb;
        for (int n = 0; n < 11; n++) begin
            if (sc_active[n]) begin
                k   = (n > 7) ? 3'd7 : 3'(n);
                lvl = {scilv2[k], scilv1[k], scilv0[k]};
                if (lvl > ipl_next) begin
                    ipl_next = lvl;
                end
            end
        end
    end

    // Timer state. Writes reload control and count and restart the
    // prescaler; otherwise each sample strobe advances the prescaler and
    // steps the counter when the prescaler reaches its terminal value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) begin
                tctl[i] <= 3'd0;
                tcnt[i] <= 8'd0;
                tps[i]  <= 7'd0;
            end
        end else if (CE) begin
            for (int i = 0; i < 3; i++) begin
                if (tim_wr[i]) begin
                    tctl[i] <= REG_DI[10:8];
                    tcnt[i] <= REG_DI[7:0];
                    tps[i]  <= 7'd0;
                end else if (SAMPLE_CE) begin
                    if (tim_hit[i]) begin
                        tps[i]  <= 7'd0;
                        tcnt[i] <= tcnt[i] + 8'd1;
                    end else begin
                        tps[i]  <= tps[i] + 7'd1;
                    end
                end
            end
        end
    end

    // Control registers, pending registers and registered outputs. Set is
    // applied after clear so a same-cycle event beats a software clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            scieb    <= 11'd0;
            scipd    <= 11'd0;
            scilv0   <= 8'd0;
            scilv1   <= 8'd0;
            scilv2   <= 8'd0;
            mcieb    <= 11'd0;
            mcipd    <= 11'd0;
            SCU_IPL  <= 3'd0;
            MAIN_INT <= 1'b0;
        end else if (CE) begin
            if (REG_WE) begin
                case (REG_A)
                    5'd3:    scieb  <= REG_DI[10:0];
                    5'd6:    scilv0 <= REG_DI[7:0];
                    5'd7:    scilv1 <= REG_DI[7:0];
                    5'd8:    scilv2 <= REG_DI[7:0];
                    5'd9:    mcieb  <= REG_DI[10:0];
                    default: ;
                endcase
            end
            scipd    <= (scipd & ~sc_clr) | ev | sc_sw;
            mcipd    <= (mcipd & ~mc_clr) | ev | mc_sw;
            SCU_IPL  <= ipl_next;
            MAIN_INT <= |(mcipd & mcieb);
        end
    end

    // Read mux; reset registers and unused addresses read as zero.
    always_comb begin
        REG_DO = 16'd0;
        case (REG_A)
            5'd0:    REG_DO = {5'd0, tctl[0], tcnt[0]};
            5'd1:    REG_DO = {5'd0, tctl[1], tcnt[1]};
            5'd2:    REG_DO = {5'd0, tctl[2], tcnt[2]};
            5'd3:    REG_DO = {5'd0, scieb};
            5'd4:    REG_DO = {5'd0, scipd};
            5'd6:    REG_DO = {8'd0, scilv0};
            5'd7:    REG_DO = {8'd0, scilv1};
            5'd8:    REG_DO = {8'd0, scilv2};
            5'd9:    REG_DO = {5'd0, mcieb};
            5'd10:   REG_DO = {5'd0, mcipd};
            default: REG_DO = 16'd0;
        endcase
    end

endmodule
